magma_uint_seq_udiv: RTL

//   Multi-cycle unsigned divider: parametrised sequential successor to the combinational

---
 rtl/magma_uint_seq_udiv.sv | 97 +++++++++
 1 files changed

// File: rtl/magma_uint_seq_udiv.sv
// Multi-cycle unsigned divider (restoring, one quotient bit per cycle) with
// valid/ready handshakes on operand and result sides.
module magma_uint_seq_udiv #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] rem_step;
  logic             accept;
  logic             last_step;

  assign accept    = in_valid && in_ready;
  assign last_step = (state == BUSY) && (cnt == '0);

  // One restoring step on a WIDTH+1 bit partial remainder.
  always_comb begin
    trial    = {rem, quo[WIDTH-1]};
    diff     = trial - {1'b0, divisor};
    take     = (trial >= {1'b0, divisor});
    rem_step = take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step = (quo << 1) | WIDTH'(take);
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Results are copied out on the final step so Q/R hold across the next operation.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      quo      <= '0;
      rem      <= '0;
      divisor  <= '0;
      cnt      <= '0;
      Q        <= '0;
      R        <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      divisor  <= I1;
      quo      <= I0;
      rem      <= '0;
      div_zero <= (I1 == '0);
      cnt      <= CW'(WIDTH - 1);
    end else if (state == BUSY) begin
      quo <= quo_step;
      rem <= rem_step;
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        Q <= quo_step;
        R <= rem_step;
      end
    end
  end

endmodule
